// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite memory slave: FSM states,
// write-request payload and the out-of-window read value.
package axi_lite_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OOB_W  = 8;

    localparam logic [DATA_W-1:0] RD_OOB_VAL = 32'h0000_0000;

    typedef enum logic [1:0] {
        W_COLLECT = 2'd0,
        W_EXEC    = 2'd1,
        W_RESP    = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_req_t;

    // Saturating add of up to two events per cycle.
    function automatic logic [OOB_W-1:0] oob_sat_add(input logic [OOB_W-1:0] cnt,
                                                     input logic [1:0]       inc);
        logic [OOB_W:0] sum;
        sum = {1'b0, cnt} + (OOB_W + 1)'(inc);
        return sum[OOB_W] ? {OOB_W{1'b1}} : sum[OOB_W-1:0];
    endfunction

endpackage

// File: rtl/sram_1r1w_be.sv
// Simple dual-port storage: one synchronous read port, one write port with
// per-byte enables. Read-before-write on a same-address collision.
module sram_1r1w_be
    import axi_lite_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic [STRB_W-1:0] we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (we[i]) begin
                mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Output register holds its value until the next enabled read.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/s_axi_lite_mem.sv
// AXI4-Lite slave backed by a byte-writable word memory, with independent
// read and write FSMs and a saturating out-of-window access counter.
module s_axi_lite_mem
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_axi_awvalid,
    output logic              mem_axi_awready,
    input  logic [ADDR_W-1:0] mem_axi_awaddr,
    input  logic [2:0]        mem_axi_awprot,
    input  logic              mem_axi_wvalid,
    output logic              mem_axi_wready,
    input  logic [DATA_W-1:0] mem_axi_wdata,
    input  logic [STRB_W-1:0] mem_axi_wstrb,
    output logic              mem_axi_bvalid,
    input  logic              mem_axi_bready,
    input  logic              mem_axi_arvalid,
    output logic              mem_axi_arready,
    input  logic [ADDR_W-1:0] mem_axi_araddr,
    input  logic [2:0]        mem_axi_arprot,
    output logic              mem_axi_rvalid,
    input  logic              mem_axi_rready,
    output logic [DATA_W-1:0] mem_axi_rdata,
    output logic [OOB_W-1:0]  oob_count
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(4 * MEM_WORDS);

    // Offset compared in 33 bits so a window ending at 2^32 cannot wrap.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr);
        return (addr >= BASE_ADDR) && ({1'b0, addr - BASE_ADDR} < WIN_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    wr_req_t           wr_q, wr_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic              rzero_q, rzero_d;
    logic [OOB_W-1:0]  oob_count_q, oob_count_d;

    logic [STRB_W-1:0] mem_we_c;
    logic              mem_re_c;
    logic [IDX_W-1:0]  mem_raddr_c;
    logic [DATA_W-1:0] mem_rdata;
    logic              w_oob_c;
    logic              r_oob_c;
    logic              unused_prot;

    assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

    // Write path: collect AW and W in any order, execute once, then respond.
    always_comb begin
        w_state_d = w_state_q;
        wr_d      = wr_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        mem_we_c  = '0;
        w_oob_c   = 1'b0;
        unique case (w_state_q)
            W_COLLECT: begin
                if (mem_axi_awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    wr_d.addr = mem_axi_awaddr;
                end
                if (mem_axi_wvalid && wready_q) begin
                    w_held_d  = 1'b1;
                    wr_d.data = mem_axi_wdata;
                    wr_d.strb = mem_axi_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_EXEC;
                end
            end
            W_EXEC: begin
                if (in_window(wr_q.addr)) begin
                    mem_we_c = wr_q.strb;
                end else begin
                    w_oob_c = 1'b1;
                end
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (mem_axi_bready) begin
                    w_state_d = W_COLLECT;
                end
            end
            default: w_state_d = W_COLLECT;
        endcase
        awready_d = (w_state_d == W_COLLECT) && !aw_held_d;
        wready_d  = (w_state_d == W_COLLECT) && !w_held_d;
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read path: storage output register is the rdata register; OOB reads mask it.
    always_comb begin
        r_state_d   = r_state_q;
        rzero_d     = rzero_q;
        mem_re_c    = 1'b0;
        r_oob_c     = 1'b0;
        mem_raddr_c = word_idx(mem_axi_araddr);
        unique case (r_state_q)
            R_IDLE: begin
                if (mem_axi_arvalid && arready_q) begin
                    r_state_d = R_RESP;
                    if (in_window(mem_axi_araddr)) begin
                        mem_re_c = 1'b1;
                        rzero_d  = 1'b0;
                    end else begin
                        rzero_d  = 1'b1;
                        r_oob_c  = 1'b1;
                    end
                end
            end
            R_RESP: begin
                if (mem_axi_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d   = (r_state_d == R_IDLE);
        rvalid_d    = (r_state_d == R_RESP);
        oob_count_d = oob_sat_add(oob_count_q, 2'({1'b0, w_oob_c} + {1'b0, r_oob_c}));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q   <= W_COLLECT;
            r_state_q   <= R_IDLE;
            wr_q        <= '0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rzero_q     <= 1'b1;
            oob_count_q <= '0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            wr_q        <= wr_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rzero_q     <= rzero_d;
            oob_count_q <= oob_count_d;
        end
    end

    sram_1r1w_be #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (word_idx(wr_q.addr)),
        .wdata (wr_q.data),
        .re    (mem_re_c),
        .raddr (mem_raddr_c),
        .rdata (mem_rdata)
    );

    assign mem_axi_awready = awready_q;
    assign mem_axi_wready  = wready_q;
    assign mem_axi_bvalid  = bvalid_q;
    assign mem_axi_arready = arready_q;
    assign mem_axi_rvalid  = rvalid_q;
    assign mem_axi_rdata   = rzero_q ? RD_OOB_VAL : mem_rdata;
    assign oob_count       = oob_count_q;

endmodule

// File: tb/tb_s_axi_lite_mem.sv
// Bench for s_axi_lite_mem: directed scenarios plus randomized traffic
// checked against an associative-array memory model.
module tb_s_axi_lite_mem;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int unsigned MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        resetn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [7:0]  oob_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem_model [int];
    int          oob_model = 0;

    always #5 clk = ~clk;

    s_axi_lite_mem #(
        .BASE_ADDR (BASE),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .mem_axi_awvalid (awvalid),
        .mem_axi_awready (awready),
        .mem_axi_awaddr  (awaddr),
        .mem_axi_awprot  (awprot),
        .mem_axi_wvalid  (wvalid),
        .mem_axi_wready  (wready),
        .mem_axi_wdata   (wdata),
        .mem_axi_wstrb   (wstrb),
        .mem_axi_bvalid  (bvalid),
        .mem_axi_bready  (bready),
        .mem_axi_arvalid (arvalid),
        .mem_axi_arready (arready),
        .mem_axi_araddr  (araddr),
        .mem_axi_arprot  (arprot),
        .mem_axi_rvalid  (rvalid),
        .mem_axi_rready  (rready),
        .mem_axi_rdata   (rdata),
        .oob_count       (oob_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_in_win(input logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        return (off >= 0) && (off < longint'(4 * MEM_WORDS));
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((longint'({32'd0, a}) - longint'({32'd0, BASE})) / 4);
    endfunction

    function automatic void model_oob();
        oob_model = (oob_model >= 255) ? 255 : oob_model + 1;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] w;
        if (!model_in_win(a)) begin
            model_oob();
            return;
        end
        w = mem_model.exists(model_idx(a)) ? mem_model[model_idx(a)] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        mem_model[model_idx(a)] = w;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!model_in_win(a)) return 32'h0;
        return mem_model.exists(model_idx(a)) ? mem_model[model_idx(a)] : 32'h0;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        oob_model = 0;
        tick();
    endtask

    // Full write transaction with independent AW/W start delays and B backpressure.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w;
        int c = 0;
        awaddr = a; wdata = d; wstrb = s; awprot = 3'($urandom);
        while (!(aw_done && w_done) && c < 50) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            if (aw_done) chk("aw_held_nrdy", awready, 0);
            if (w_done)  chk("w_held_nrdy", wready, 0);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            c++;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done  = 1;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) begin
            chk("wr_accept_timeout", 0, 1);
            return;
        end
        chk("b_not_yet", bvalid, 0);
        tick();
        chk("b_latency", bvalid, 1);
        model_write(a, d, s);
        repeat (b_dly) begin
            chk("b_hold", {29'd0, bvalid, awready, wready}, 32'b100);
            tick();
        end
        bready = 1;
        tick();
        bready = 0;
        chk("b_done", bvalid, 0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int r_dly, output logic [31:0] d);
        bit hs = 0;
        int c = 0;
        d = 32'hx;
        arvalid = 1; araddr = a; arprot = 3'($urandom);
        while (!hs && c < 50) begin
            hs = arready;
            tick();
            c++;
        end
        arvalid = 0;
        if (!hs) begin
            chk("rd_accept_timeout", 0, 1);
            return;
        end
        if (!model_in_win(a)) model_oob();
        chk("r_valid", rvalid, 1);
        d = rdata;
        repeat (r_dly) begin
            tick();
            chk("r_stable", rdata, d);
            chk("r_hold_valid", rvalid, 1);
        end
        rready = 1;
        tick();
        rready = 0;
        chk("r_done", rvalid, 0);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input int r_dly);
        logic [31:0] exp, got;
        exp = model_read(a);
        axi_read(a, r_dly, got);
        chk(tag, got, exp);
        chk("oob_model", 32'(oob_count), 32'(oob_model));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] got, a, d;
        resetn = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_oob", 32'(oob_count), 0);
        resetn = 1;
        tick();
        chk("rst_readies", {29'd0, awready, wready, arready}, 32'b111);

        // W before AW
        axi_write(32'h10, 32'hCAFE_F00D, 4'hF, 3, 0, 0);
        axi_read(32'h10, 0, got);
        chk("wb4a_data", got, 32'hCAFE_F00D);

        // Byte strobes, including an empty strobe
        axi_write(32'h20, 32'h1122_3344, 4'hF, 0, 0, 0);
        axi_write(32'h20, 32'hAABB_CCDD, 4'b0101, 1, 0, 0);
        axi_read(32'h20, 0, got);
        chk("strb_data", got, 32'h11BB_33DD);
        axi_write(32'h23, 32'hFFFF_FFFF, 4'b0000, 0, 2, 0);
        read_check("strb_zero", 32'h20, 0);

        // Backpressure on B and R
        axi_write(32'h30, 32'h0BAD_BEEF, 4'hF, 0, 0, 5);
        read_check("bp_read", 32'h30, 5);

        // Read coincident with the execute cycle of a same-word write
        axi_write(32'h40, 32'd5, 4'hF, 0, 0, 0);
        awaddr = 32'h40; wdata = 32'd9; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        chk("sim_wr_rdy", {30'd0, awready, wready}, 32'b11);
        tick();
        awvalid = 0; wvalid = 0; araddr = 32'h40; arvalid = 1;
        chk("sim_ar_rdy", arready, 1);
        tick();
        arvalid = 0;
        chk("sim_bvalid", bvalid, 1);
        chk("sim_rvalid", rvalid, 1);
        chk("sim_old_data", rdata, 32'd5);
        model_write(32'h40, 32'd9, 4'hF);
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        axi_read(32'h40, 0, got);
        chk("sim_new_data", got, 32'd9);

        // Reset while a response is pending
        awaddr = 32'h80; wdata = 32'h1357_9BDF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        tick();
        chk("mid_bvalid_pre", bvalid, 1);
        model_write(32'h80, 32'h1357_9BDF, 4'hF);
        #2 resetn = 0;
        #1;
        chk("mid_bvalid_rst", bvalid, 0);
        chk("mid_rvalid_rst", rvalid, 0);
        oob_model = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        tick();
        chk("mid_readies", {29'd0, awready, wready, arready}, 32'b111);
        chk("mid_bvalid_post", bvalid, 0);
        read_check("mid_mem_kept", 32'h80, 0);
        read_check("mid_mem_kept2", 32'h20, 1);

        // Out-of-window accesses and saturation
        axi_write(32'h0, 32'h0000_1111, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'(4 * MEM_WORDS), 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read(32'hFFFF_FFFC, 0, got);
        chk("oob_rdata", got, 32'h0);
        chk("oob_count2", 32'(oob_count), 32'd2);
        axi_read(32'h0, 0, got);
        chk("oob_mem_kept", got, 32'h0000_1111);
        awaddr = 32'h8000_0000; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; araddr = 32'h0000_1000; arvalid = 1;
        tick();
        arvalid = 0;
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        model_oob(); model_oob();
        chk("oob_dual_event", 32'(oob_count), 32'd4);
        for (int i = 0; i < 300; i++) begin
            if (i % 3 == 0) axi_write(32'h0000_0400 + 32'(4 * i), 32'(i), 4'hF, 0, 0, 0);
            else axi_read(32'hFFFF_0000 + 32'(4 * i), 0, got);
        end
        chk("oob_saturate", 32'(oob_count), 32'hFF);
        chk("oob_sat_model", 32'(oob_count), 32'(oob_model));
        read_check("oob_mem_kept2", 32'h0, 0);

        // Randomized traffic
        do_reset();
        for (int w = 0; w < 32; w++) axi_write(32'(4 * w), $urandom, 4'hF, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                case ($urandom_range(0, 2))
                    0:       a = BASE + 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 400));
                    1:       a = 32'hFFFF_FFFC - 32'($urandom_range(0, 64));
                    default: a = $urandom | 32'h8000_0000;
                endcase
            end else begin
                a = 32'(4 * $urandom_range(0, 31) + $urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                axi_write(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2));
                chk("rnd_oob_w", 32'(oob_count), 32'(oob_model));
            end else begin
                read_check("rnd_read", a, $urandom_range(0, 2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/s_axi_lite_mem.md
S_AXI_LITE_MEM -- requirements
Module: s_axi_lite_mem

Interface
REQ-001 The block SHALL take parameter BASE_ADDR, default 32'h0000_0000, the byte address of word 0.
REQ-002 The block SHALL take parameter MEM_WORDS, default 1024, the number of 32-bit words stored (power of two, 16..65536).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, the reset: asynchronous assert, active-low.
REQ-005 The write address ports SHALL be: mem_axi_awvalid in 1; mem_axi_awready out 1; mem_axi_awaddr in 32; mem_axi_awprot in 3, ignored.
REQ-006 The write data ports SHALL be: mem_axi_wvalid in 1; mem_axi_wready out 1; mem_axi_wdata in 32; mem_axi_wstrb in 4.
REQ-007 The write response ports SHALL be: mem_axi_bvalid out 1; mem_axi_bready in 1.
REQ-008 The read address ports SHALL be: mem_axi_arvalid in 1; mem_axi_arready out 1; mem_axi_araddr in 32; mem_axi_arprot in 3, ignored.
REQ-009 The read data ports SHALL be: mem_axi_rvalid out 1; mem_axi_rready in 1; mem_axi_rdata out 32.
REQ-010 The block SHALL have port oob_count, output, 8, a saturating count of out-of-window accesses.

Function
REQ-011 Address decode SHALL work as follows:
- in-window when BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS, using 32-bit unsigned compare with no wrap;
- word index = (addr - BASE_ADDR) >> 2, so addr[1:0] is ignored.
REQ-012 The write path SHALL be a 3-state FSM, W_COLLECT -> W_EXEC -> W_RESP -> W_COLLECT.
REQ-013 In W_COLLECT the write-channel ready outputs SHALL behave as follows:
- awready = !aw_held and wready = !w_held;
- AW and W are captured independently, in either order or in the same cycle.
REQ-014 The FSM SHALL move from W_COLLECT to W_EXEC on the edge where both AW and W are held (counting captures made on that edge).
REQ-015 In W_EXEC (exactly one cycle) the block SHALL write each byte lane i where wstrb[i]=1 if in-window, then clear aw_held and w_held.
REQ-016 wstrb=4'b0000 SHALL write nothing and still produce a response.
REQ-017 In W_RESP, bvalid SHALL be 1 until the bready handshake; awready and wready SHALL be 0.
REQ-018 Write latency SHALL be: last of AW/W accepted at edge N -> memory updated at edge N+1 -> bvalid high from edge N+1.
REQ-019 The read path SHALL be a 2-state FSM, R_IDLE -> R_RESP -> R_IDLE.
REQ-020 arready SHALL equal 1 in R_IDLE and 0 in R_RESP.
REQ-021 On AR handshake at edge N, rdata SHALL be registered at edge N, and rvalid high from edge N until the rready handshake.
REQ-022 rdata SHALL hold stable while rvalid=1 and rready=0.
REQ-023 An out-of-window read SHALL return 32'h0000_0000.
REQ-024 The read and write FSMs SHALL run concurrently (separate read/write ports on the storage array).
REQ-025 A same-word write in W_EXEC coincident with an AR handshake SHALL return the old data.
REQ-026 oob_count SHALL increment by 1 per out-of-window write (in W_EXEC) and per out-of-window read (at AR handshake).
REQ-027 When both count events fall in the same cycle, oob_count SHALL add 2, saturating at 8'hFF.
REQ-028 An out-of-window write SHALL leave memory unchanged and still complete with bvalid.
REQ-029 No output SHALL combinationally depend on any valid/ready input.

Reset
REQ-030 While resetn=0, the block SHALL hold:
- write FSM = W_COLLECT, aw_held = w_held = 0;
- read FSM = R_IDLE;
- bvalid = 0, rvalid = 0, rdata = 0, oob_count = 0;
- awready = wready = arready = 1 after release.
REQ-031 Reset mid-transaction SHALL drop the pending operation; a write in W_EXEC at the reset edge SHALL not be guaranteed.
REQ-032 Memory contents SHALL NOT be reset.

Structure
REQ-033 FSM state typedefs (w_state_t, r_state_t) and the out-of-window read value SHALL live in shared package axi_lite_pkg.
REQ-034 Storage SHALL be one sub-module, sram_1r1w_be (synchronous read, per-byte write enable, MEM_WORDS x 32).

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Write before address: W (wdata 32'hCAFE_F00D, wstrb 4'hF) accepted cycle 0, AW 0x10 cycle 3 -> bvalid from cycle 4; read 0x10 returns 32'hCAFE_F00D one cycle after the AR handshake.
- Byte strobes: word 0x20 = 32'h1122_3344, then write 32'hAABB_CCDD with wstrb 4'b0101 -> read returns 32'h11BB_33DD.
- Backpressure: bready=0 for 5 cycles -> bvalid stays 1 and awready/wready stay 0; rready=0 for 5 cycles -> rdata stable.
- Out-of-window: write to BASE_ADDR+4*MEM_WORDS, then read of 0xFFFF_FFFC -> memory unchanged, rdata=0, oob_count=2; 300 OOB accesses -> oob_count=8'hFF.
- Simultaneous read and write: word 0x40 = 5, write 9 in W_EXEC with an AR to 0x40 on the same edge -> rdata=5; next read = 9.
- Reset mid-operation: assert resetn=0 while in W_RESP with bvalid=1 -> bvalid=0 immediately; all readies 1 after release.
